// File: rtl/mem_if_pkg.sv
// Shared definitions for the L2-to-main-memory RAS/CAS link: state encoding,
// address field positions and the default timing both ends agree on.
package mem_if_pkg;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 64;
   // Byte offset of a 64-bit word; column field starts just above it.
   localparam int WORD_LSB = 3;

   localparam int DEF_ROW_BITS = 8;
   localparam int DEF_COL_BITS = 6;
   localparam int DEF_T_RCD    = 2;
   localparam int DEF_CAS_LAT  = 2;
   localparam int DEF_T_RP     = 2;
   localparam int DEF_BURST    = 4;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVATE,
      ROW_OPEN,
      READ_LAT,
      READ_BURST,
      WRITE_BURST,
      PRECHARGE
   } mem_state_e;

   function automatic int row_lsb(input int col_bits);
      return WORD_LSB + col_bits;
   endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Command/data bundle between the L2 controller (master) and main memory (slave).
interface main_memory_responder_if;
   import mem_if_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic              cs;
   logic              ras;
   logic              cas;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              stb;
   logic              busy;
   logic              err;

   modport master (
      output addr, cs, ras, cas, we, wdata,
      input  rdata, stb, busy, err
   );

   modport slave (
      input  addr, cs, ras, cas, we, wdata,
      output rdata, stb, busy, err
   );

endinterface

// File: rtl/mem_array_sp.sv
// Single-port synchronous word array with a registered read port.
// Contents are never reset; only the read register clears.
module mem_array_sp #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory end of the RAS/CAS link: decodes L2 commands, times activate,
// CAS latency and precharge, and streams wrap-ordered bursts to/from the array.
module main_memory_responder
   import mem_if_pkg::*;
#(
   parameter int ROW_BITS = DEF_ROW_BITS,
   parameter int COL_BITS = DEF_COL_BITS,
   parameter int T_RCD    = DEF_T_RCD,
   parameter int CAS_LAT  = DEF_CAS_LAT,
   parameter int T_RP     = DEF_T_RP,
   parameter int BURST    = DEF_BURST
) (
   input logic                   clk,
   input logic                   rst_n,
   main_memory_responder_if.slave bus
);

   localparam int WORD_W = ROW_BITS + COL_BITS;
   localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int CNT_W  = 8;

   mem_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [COL_BITS-1:0] col_q, col_d;
   logic                we_q, we_d;
   logic                stb_q, busy_q, err_q, err_d;
   logic                illegal;
   logic                ram_en, ram_we;
   logic [BEAT_W-1:0]   ram_beat;
   logic [WORD_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_rdata;
   logic                addr_unused;

   function automatic logic is_busy(input mem_state_e s);
      return s inside {ACTIVATE, READ_LAT, READ_BURST, WRITE_BURST, PRECHARGE};
   endfunction

   // Beat k stays inside the aligned BURST block; the carry never reaches the row.
   function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] base,
                                                     input logic [BEAT_W-1:0]   k);
      logic [COL_BITS-1:0] mask;
      mask = COL_BITS'(BURST - 1);
      return (base & ~mask) | ((base + COL_BITS'(k)) & mask);
   endfunction

   // While busy, ras must stay high except during precharge, and cas must stay low.
   assign illegal = is_busy(state_q) && bus.cs &&
                    (bus.cas || (bus.ras != (state_q != PRECHARGE)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      row_d   = row_q;
      col_d   = col_q;
      we_d    = we_q;
      err_d   = illegal;
      case (state_q)
         IDLE: begin
            if (bus.cs && bus.ras) begin
               row_d   = bus.addr[row_lsb(COL_BITS) +: ROW_BITS];
               cnt_d   = CNT_W'(T_RCD - 1);
               state_d = ACTIVATE;
            end else if (bus.cs && bus.cas) begin
               err_d = 1'b1;
            end
         end
         ACTIVATE: begin
            if (cnt_q == '0) state_d = ROW_OPEN;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ROW_OPEN: begin
            if (bus.cs && !bus.ras) begin
               cnt_d   = CNT_W'(T_RP - 1);
               state_d = PRECHARGE;
            end else if (bus.cs && bus.cas) begin
               col_d  = bus.addr[WORD_LSB +: COL_BITS];
               we_d   = bus.we;
               beat_d = '0;
               if (bus.we) begin
                  state_d = WRITE_BURST;
               end else begin
                  cnt_d   = CNT_W'(CAS_LAT - 1);
                  state_d = READ_LAT;
               end
            end
         end
         READ_LAT: begin
            if (cnt_q == '0) begin
               beat_d  = '0;
               state_d = READ_BURST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         READ_BURST, WRITE_BURST: begin
            if (beat_q == BEAT_W'(BURST - 1)) state_d = ROW_OPEN;
            else                              beat_d  = beat_q + 1'b1;
         end
         PRECHARGE: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reads are issued on the edge that presents the beat, so the array's
   // registered output lines up with stb; writes land on the edge ending the beat.
   assign ram_we   = (state_q == WRITE_BURST);
   assign ram_en   = ram_we || (state_d == READ_BURST);
   assign ram_beat = ram_we ? beat_q : beat_d;
   assign ram_addr = {row_q, burst_col(col_q, ram_beat)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         beat_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         col_q   <= col_d;
         we_q    <= we_d;
         stb_q   <= (state_d == READ_BURST) || (state_d == WRITE_BURST);
         busy_q  <= is_busy(state_d);
         err_q   <= err_d;
      end
   end

   mem_array_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (WORD_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (bus.wdata),
      .rdata_o (ram_rdata)
   );

   assign bus.rdata = ram_rdata;
   assign bus.stb   = stb_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

   assign addr_unused = ^{bus.addr[ADDR_W-1:WORD_LSB+COL_BITS+ROW_BITS],
                          bus.addr[WORD_LSB-1:0]};

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: timing, bursts, wrap order,
// illegal commands, precharge priority and asynchronous reset mid-burst.
module tb_main_memory_responder;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [3:0][63:0] pat;
   logic [3:0][63:0] nw;
   logic [3:0][63:0] d;
   logic [3:0][63:0] exp_d;
   int               lat;
   int               nstb;

   main_memory_responder_if bus ();

   main_memory_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic ras, input logic cas,
                        input logic we, input logic [31:0] a);
      bus.cs   = cs;
      bus.ras  = ras;
      bus.cas  = cas;
      bus.we   = we;
      bus.addr = a;
   endtask

   task automatic activate(input logic [31:0] a);
      drive(1, 1, 0, 0, a);
      tick();
      drive(0, 0, 0, 0, a);
      tick();
      tick();
   endtask

   task automatic precharge();
      drive(1, 0, 0, 0, bus.addr);
      tick();
      drive(0, 0, 0, 0, bus.addr);
      tick();
      tick();
   endtask

   // Issues a read CAS, holds ras high through the burst, records latency and beats.
   task automatic do_read(input logic [31:0] a, output logic [3:0][63:0] dq,
                          output int lat_o, output int nstb_o);
      drive(1, 1, 1, 0, a);
      tick();
      drive(1, 1, 0, 0, a);
      lat_o = 0;
      while (bus.stb !== 1'b1 && lat_o < 10) begin
         tick();
         lat_o++;
      end
      nstb_o = 0;
      for (int k = 0; k < 4; k++) begin
         dq[k] = bus.rdata;
         if (bus.stb === 1'b1) nstb_o++;
         tick();
      end
      drive(0, 0, 0, 0, a);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.wdata = '0;
      drive(0, 0, 0, 0, 32'h0);
      tick();
      tick();
      n_tests++; if (bus.stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", bus.stb); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      n_tests++; if (bus.rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
      rst_n = 1'b1;
      tick();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_timing();
      drive(1, 1, 0, 0, 32'h200);
      tick();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL act_busy1: got %b expected 1", bus.busy); end
      tick();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL act_busy2: got %b expected 1", bus.busy); end
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL act_ras_hold_err: got %b expected 0", bus.err); end
      tick();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL act_open: got %b expected 0", bus.busy); end
      drive(1, 0, 0, 0, 32'h200);
      tick();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pre_busy1: got %b expected 1", bus.busy); end
      drive(0, 0, 0, 0, 32'h200);
      tick();
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pre_busy2: got %b expected 1", bus.busy); end
      tick();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL pre_idle: got %b expected 0", bus.busy); end
   endtask

   task automatic test_write_read();
      activate(32'h200);
      drive(1, 1, 1, 1, 32'h200);
      tick();
      drive(0, 0, 0, 0, 32'h200);
      for (int k = 0; k < 4; k++) begin
         bus.wdata = pat[k];
         n_tests++; if (bus.stb !== 1'b1) begin n_fail++; $display("FAIL wr_stb%0d: got %b expected 1", k, bus.stb); end
         tick();
      end
      n_tests++; if (bus.stb !== 1'b0) begin n_fail++; $display("FAIL wr_stb_end: got %b expected 0", bus.stb); end
      do_read(32'h200, d, lat, nstb);
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", lat); end
      n_tests++; if (nstb != 4) begin n_fail++; $display("FAIL rd_stb_count: got %0d expected 4", nstb); end
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (d[k] !== pat[k]) begin n_fail++; $display("FAIL rd_beat%0d: got %h expected %h", k, d[k], pat[k]); end
      end
      n_tests++; if (bus.stb !== 1'b0) begin n_fail++; $display("FAIL rd_stb_end: got %b expected 0", bus.stb); end
   endtask

   task automatic test_wrap();
      exp_d[0] = pat[2];
      exp_d[1] = pat[3];
      exp_d[2] = pat[0];
      exp_d[3] = pat[1];
      do_read(32'h210, d, lat, nstb);
      n_tests++; if (nstb != 4) begin n_fail++; $display("FAIL wrap_stb_count: got %0d expected 4", nstb); end
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (d[k] !== exp_d[k]) begin n_fail++; $display("FAIL wrap_beat%0d: got %h expected %h", k, d[k], exp_d[k]); end
      end
   endtask

   task automatic test_illegal();
      drive(1, 1, 1, 0, 32'h200);
      tick();
      drive(1, 1, 0, 0, 32'h200);
      tick();
      tick();
      n_tests++; if (bus.stb !== 1'b1 || bus.rdata !== pat[0]) begin n_fail++; $display("FAIL ill_beat0: got stb=%b %h expected stb=1 %h", bus.stb, bus.rdata, pat[0]); end
      bus.wdata = 64'hDEAD_BEEF_DEAD_BEEF;
      drive(1, 1, 1, 1, 32'h208);
      tick();
      n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ill_burst_err: got %b expected 1", bus.err); end
      n_tests++; if (bus.rdata !== pat[1]) begin n_fail++; $display("FAIL ill_burst_beat1: got %h expected %h", bus.rdata, pat[1]); end
      drive(1, 1, 0, 0, 32'h200);
      tick();
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ill_burst_err_pulse: got %b expected 0", bus.err); end
      tick();
      tick();
      n_tests++; if (bus.stb !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ill_burst_end: got stb=%b busy=%b expected 0 0", bus.stb, bus.busy); end
      drive(0, 0, 0, 0, 32'h200);
      do_read(32'h200, d, lat, nstb);
      n_tests++; if (d !== pat) begin n_fail++; $display("FAIL ill_burst_array: got %h expected %h", d, pat); end
      precharge();
      drive(1, 0, 1, 1, 32'h200);
      tick();
      n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ill_idle_err: got %b expected 1", bus.err); end
      n_tests++; if (bus.stb !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ill_idle_quiet: got stb=%b busy=%b expected 0 0", bus.stb, bus.busy); end
      drive(0, 0, 0, 0, 32'h200);
      tick();
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL ill_idle_err_pulse: got %b expected 0", bus.err); end
   endtask

   task automatic test_priority();
      activate(32'h200);
      bus.wdata = 64'hBAD0_BAD0_BAD0_BAD0;
      drive(1, 0, 1, 1, 32'h200);
      tick();
      n_tests++; if (bus.busy !== 1'b1 || bus.stb !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL prio_precharge: got busy=%b stb=%b err=%b expected 1 0 0", bus.busy, bus.stb, bus.err); end
      drive(0, 0, 0, 0, 32'h200);
      tick();
      tick();
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b expected 0", bus.busy); end
      activate(32'h200);
      do_read(32'h200, d, lat, nstb);
      n_tests++; if (d !== pat) begin n_fail++; $display("FAIL prio_array: got %h expected %h", d, pat); end
   endtask

   task automatic test_reset_midburst();
      drive(1, 1, 1, 1, 32'h200);
      tick();
      drive(0, 0, 0, 0, 32'h200);
      bus.wdata = nw[0];
      tick();
      bus.wdata = nw[1];
      tick();
      bus.wdata = nw[2];
      n_tests++; if (bus.stb !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stb_before: got %b expected 1", bus.stb); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.stb !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async: got stb=%b busy=%b expected 0 0", bus.stb, bus.busy); end
      tick();
      tick();
      rst_n = 1'b1;
      drive(1, 0, 1, 0, 32'h200);
      tick();
      n_tests++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got err=%b busy=%b expected 1 0", bus.err, bus.busy); end
      drive(0, 0, 0, 0, 32'h200);
      tick();
      activate(32'h200);
      exp_d[0] = nw[0];
      exp_d[1] = nw[1];
      exp_d[2] = pat[2];
      exp_d[3] = pat[3];
      do_read(32'h200, d, lat, nstb);
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (d[k] !== exp_d[k]) begin n_fail++; $display("FAIL rst_mid_beat%0d: got %h expected %h", k, d[k], exp_d[k]); end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      pat[0] = 64'h1111_1111_1111_1111;
      pat[1] = 64'h2222_2222_2222_2222;
      pat[2] = 64'h3333_3333_3333_3333;
      pat[3] = 64'h4444_4444_4444_4444;
      nw[0]  = 64'hAAAA_AAAA_AAAA_AAAA;
      nw[1]  = 64'hBBBB_BBBB_BBBB_BBBB;
      nw[2]  = 64'hCCCC_CCCC_CCCC_CCCC;
      nw[3]  = 64'hDDDD_DDDD_DDDD_DDDD;
      test_reset();
      test_timing();
      test_write_read();
      test_wrap();
      test_illegal();
      test_priority();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
